// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor scan scheduler and the per-channel
// sensor/relay controllers that run on the same 16 ms system tick.
package sensor_pkg;

  // 16 ms tick count that approximates one second. The channel controllers
  // use it for their own timeouts.
  localparam int TICKS_PER_S = 63;

  // Scheduler state encoding, 3 bits wide.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_ENABLE = 3'd2;
  localparam logic [2:0] ST_NEXT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SELECT = ST_SELECT,
    ENABLE = ST_ENABLE,
    NEXT   = ST_NEXT,
    DONE   = ST_DONE
  } scan_state_e;

  // Larger of two integers. Used to size counters that serve two intervals.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sensor_scan_scheduler_if.sv
// Bundle between top-level run control / channel controllers and the scan
// scheduler. The master side is the scheduler itself; the slave side is the
// surrounding logic that supplies run control and fault flags.
interface sensor_scan_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
);

  logic            start;
  logic            clear_mask;
  logic [N_CH-1:0] ch_fault;
  logic [CH_W-1:0] sen_sel;
  logic [N_CH-1:0] ch_enable;
  logic [N_CH-1:0] fault_mask;
  logic            busy;
  logic            scan_done;
  logic            all_fault;

  modport master (
    input  start, clear_mask, ch_fault,
    output sen_sel, ch_enable, fault_mask, busy, scan_done, all_fault
  );

  modport slave (
    output start, clear_mask, ch_fault,
    input  sen_sel, ch_enable, fault_mask, busy, scan_done, all_fault
  );

endinterface

// File: rtl/next_unmasked_ch.sv
// Combinational priority search for the next channel that is not masked.
// With from_zero set it returns the lowest unmasked index; otherwise it
// returns the lowest unmasked index strictly above cur. No wrap-around.
module next_unmasked_ch #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur,
  input  logic            from_zero,
  output logic [CH_W-1:0] idx,
  output logic            found
);

  // Scan from the top down so the last hit, which is the lowest index, wins.
  always_comb begin
    // NOTE: outputs get a default before the loop, so no path leaves them
    // unassigned and no latch is inferred.
    idx   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (!mask[i] && (from_zero || (CH_W'(i) > cur))) begin
        idx   = CH_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_scan_scheduler.sv
// Round-robin scheduler that time-shares the sensor mux and comparator among
// N_CH channel controllers. For each channel it drives the mux select for
// SETTLE ticks. It then grants that channel's enable for DWELL ticks and
// samples the channel's fault flag on the last tick. Faulted channels are
// latched into a sticky mask and skipped until clear_mask.
module sensor_scan_scheduler
  import sensor_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int SETTLE = 2,
  parameter int DWELL  = 4,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic                      clk_16ms,
  input  logic                      rst,
  sensor_scan_scheduler_if.master   bus
);

  // One counter serves both the settle and the dwell interval.
  localparam int CNT_W = $clog2(max_int(SETTLE, DWELL)) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);

  scan_state_e      state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [CH_W-1:0]  srch_idx;
  logic             srch_found;
  logic             all_fault;

  assign all_fault = &mask_q;

  // NEXT looks strictly above the current channel; IDLE and DONE restart
  // from the lowest unmasked channel.
  next_unmasked_ch #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_search (
    .mask      (mask_q),
    .cur       (ptr_q),
    .from_zero (state_q != NEXT),
    .idx       (srch_idx),
    .found     (srch_found)
  );

  // Next-state, pointer, counter, select and fault-mask update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    // The clear is applied first, so a capture on the same tick survives it.
    mask_d  = bus.clear_mask ? '0 : mask_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !all_fault && srch_found) begin
          ptr_d   = srch_idx;
          sel_d   = srch_idx;
          cnt_d   = '0;
          state_d = SELECT;
        end
      end

      SELECT: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ENABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ENABLE: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (bus.ch_fault[ptr_q]) begin
            mask_d[ptr_q] = 1'b1;
          end
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      NEXT: begin
        // Dropping start only takes effect between channels, so the window
        // that was in progress always completes.
        if (!bus.start) begin
          state_d = IDLE;
        end else if (srch_found) begin
          ptr_d   = srch_idx;
          sel_d   = srch_idx;
          state_d = SELECT;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (!all_fault && bus.start && srch_found) begin
          ptr_d   = srch_idx;
          sel_d   = srch_idx;
          cnt_d   = '0;
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_16ms) begin
    // NOTE: non-blocking assignments make every register see the values from
    // before the edge, whatever order the statements are written in.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.sen_sel    = sel_q;
  assign bus.fault_mask = mask_q;
  assign bus.all_fault  = all_fault;
  assign bus.busy       = (state_q != IDLE);
  assign bus.scan_done  = (state_q == DONE);
  assign bus.ch_enable  = (state_q == ENABLE) ? (N_CH'(1) << ptr_q) : '0;

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Self-checking bench for sensor_scan_scheduler. A procedural timeline model
// predicts every output on every tick; directed phases cover the scan timing,
// fault skipping, all-fault stop, mid-scan stop, clear/capture collision and
// reset, and a randomized phase exercises the mix.
module tb_sensor_scan_scheduler;

  localparam int N_CH   = 4;
  localparam int SETTLE = 2;
  localparam int DWELL  = 4;
  localparam int CH_W   = $clog2(N_CH);
  localparam int PER_CH = SETTLE + DWELL + 1;

  localparam int OBS_EN   = 0;
  localparam int OBS_MASK = 1;
  localparam int OBS_SEL  = 2;
  localparam int OBS_DONE = 3;

  logic clk_16ms = 1'b0;
  logic rst      = 1'b1;

  sensor_scan_scheduler_if #(.N_CH(N_CH), .CH_W(CH_W)) bus ();

  sensor_scan_scheduler #(
    .N_CH   (N_CH),
    .SETTLE (SETTLE),
    .DWELL  (DWELL),
    .CH_W   (CH_W)
  ) dut (
    .clk_16ms (clk_16ms),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_16ms = ~clk_16ms;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CH_W-1:0] m_sel;
  logic [N_CH-1:0] m_en;
  logic [N_CH-1:0] m_mask;
  logic [N_CH-1:0] s_mask;
  logic            m_busy;
  logic            m_done;
  logic            m_rst;
  logic            s_start;

  // Lowest unmasked channel index strictly above 'above'; -1 if none.
  function automatic int first_free(input logic [N_CH-1:0] m, input int above);
    for (int i = above + 1; i < N_CH; i++) begin
      if (!m[i]) return i;
    end
    return -1;
  endfunction

  // One clock edge: snapshot pre-edge start and mask, then apply reset or
  // clear followed by an optional fault capture for channel ch.
  task automatic model_tick(input bit cap, input int ch);
    @(posedge clk_16ms);
    s_start = bus.start;
    s_mask  = m_mask;
    if (rst) begin
      m_rst  = 1'b1;
      m_mask = '0;
      m_sel  = '0;
      m_en   = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      if (bus.clear_mask) m_mask = '0;
      if (cap && bus.ch_fault[ch]) m_mask[ch] = 1'b1;
    end
  endtask

  // Timeline of scans: wait for a start, then walk channels in order with a
  // settle, a dwell and a one-tick gap each, then one DONE tick per scan.
  task automatic model_flow();
    int ch;
    int nxt;
    bit go;
    bit active;
    forever begin
      m_busy = 1'b0;
      m_en   = '0;
      m_done = 1'b0;
      go = 1'b0;
      while (!go) begin
        model_tick(1'b0, 0);
        if (m_rst) return;
        go = s_start && !(&s_mask);
      end
      ch = first_free(s_mask, -1);
      active = 1'b1;
      while (active) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        m_sel  = CH_W'(ch);
        repeat (SETTLE) begin
          model_tick(1'b0, 0);
          if (m_rst) return;
        end
        m_en = '0;
        m_en[ch] = 1'b1;
        for (int d = 0; d < DWELL; d++) begin
          model_tick(d == DWELL - 1, ch);
          if (m_rst) return;
        end
        m_en = '0;
        model_tick(1'b0, 0);
        if (m_rst) return;
        nxt = first_free(s_mask, ch);
        if (!s_start) begin
          active = 1'b0;
        end else if (nxt >= 0) begin
          ch = nxt;
        end else begin
          m_done = 1'b1;
          model_tick(1'b0, 0);
          if (m_rst) return;
          m_done = 1'b0;
          if (!(&s_mask) && s_start) ch = first_free(s_mask, -1);
          else active = 1'b0;
        end
      end
    end
  endtask

  initial begin
    m_sel  = '0;
    m_en   = '0;
    m_mask = '0;
    s_mask = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    forever begin
      m_rst = 1'b0;
      model_flow();
    end
  end

  // Compare every output with the model half a cycle after each edge.
  always @(negedge clk_16ms) begin
    check("sen_sel",    32'(bus.sen_sel),    32'(m_sel));
    check("ch_enable",  32'(bus.ch_enable),  32'(m_en));
    check("fault_mask", 32'(bus.fault_mask), 32'(m_mask));
    check("busy",       32'(bus.busy),       32'(m_busy));
    check("scan_done",  32'(bus.scan_done),  32'(m_done));
    check("all_fault",  32'(bus.all_fault),  32'(&m_mask));
  end

  // ---------------- directed and random stimulus ----------------
  function automatic logic [31:0] observe(input int sel);
    case (sel)
      OBS_EN:   return 32'(bus.ch_enable);
      OBS_MASK: return 32'(bus.fault_mask);
      OBS_SEL:  return 32'(bus.sen_sel);
      default:  return 32'(bus.scan_done);
    endcase
  endfunction

  // Bounded wait for an observed output to reach a value; a timeout fails.
  task automatic wait_for(input string tag, input int sel, input logic [31:0] val,
                          input int budget);
    logic [31:0] cur;
    cur = observe(sel);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_16ms);
      cur = observe(sel);
      if (cur == val) break;
    end
    check(tag, cur, val);
  endtask

  task automatic pulse_clear();
    bus.clear_mask = 1'b1;
    @(negedge clk_16ms);
    bus.clear_mask = 1'b0;
  endtask

  initial begin
    int n;
    int n_done;
    bit saw_en1;
    bit saw_done;

    bus.start      = 1'b0;
    bus.clear_mask = 1'b0;
    bus.ch_fault   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk_16ms);
    check("rst_en",   32'(bus.ch_enable),  32'h0);
    check("rst_busy", 32'(bus.busy),       32'h0);
    check("rst_mask", 32'(bus.fault_mask), 32'h0);
    rst = 1'b0;
    @(negedge clk_16ms);

    // Fault-free scans: enable latency, first scan length, repeat period.
    bus.start = 1'b1;
    n = 0;
    while (bus.ch_enable == '0 && n < 50) begin
      @(negedge clk_16ms);
      n++;
    end
    check("en_latency", 32'(n), 32'(SETTLE + 1));
    while (!bus.scan_done && n < 100) begin
      @(negedge clk_16ms);
      n++;
    end
    check("first_done", 32'(n), 32'(N_CH * PER_CH + 1));
    for (n = 1; n < 100; n++) begin
      @(negedge clk_16ms);
      if (bus.scan_done) break;
    end
    check("period_full", 32'(n), 32'(N_CH * PER_CH + 1));

    // Channel 2 faults: it gets masked and the scan shortens by one slot.
    bus.ch_fault = 4'b0100;
    wait_for("mask_ch2", OBS_MASK, 32'h4, 100);
    bus.ch_fault = '0;
    wait_for("done_after_cap", OBS_DONE, 32'h1, 100);
    for (n = 1; n < 100; n++) begin
      @(negedge clk_16ms);
      if (bus.scan_done) break;
    end
    check("period_skip2", 32'(n), 32'((N_CH - 1) * PER_CH + 1));

    // Start dropped during channel 1 settle: window completes, no scan_done.
    wait_for("en_ch0", OBS_EN, 32'h1, 100);
    wait_for("sel_ch1", OBS_SEL, 32'h1, 20);
    bus.start = 1'b0;
    saw_en1  = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk_16ms);
      if (bus.ch_enable == 4'b0010) saw_en1 = 1'b1;
      if (bus.scan_done) saw_done = 1'b1;
    end
    check("drop_en1",      32'(saw_en1),  32'h1);
    check("drop_no_done",  32'(saw_done), 32'h0);
    check("drop_idle",     32'(bus.busy), 32'h0);
    check("drop_sel_hold", 32'(bus.sen_sel), 32'h1);

    // Every channel faults: one scan_done, then idle with start still high.
    bus.ch_fault = '1;
    bus.start    = 1'b1;
    wait_for("allf_done", OBS_DONE, 32'h1, 100);
    check("allf_mask", 32'(bus.fault_mask), 32'hF);
    check("allf_flag", 32'(bus.all_fault),  32'h1);
    n_done = 0;
    repeat (30) begin
      @(negedge clk_16ms);
      if (bus.scan_done) n_done++;
    end
    check("allf_no_more_done", 32'(n_done),   32'h0);
    check("allf_idle",         32'(bus.busy), 32'h0);

    // Clear on the same tick as the capture of channel 3, prior mask 0001.
    bus.ch_fault = 4'b0001;
    pulse_clear();
    wait_for("mask_0001", OBS_MASK, 32'h1, 100);
    bus.ch_fault = 4'b1000;
    wait_for("en_ch3", OBS_EN, 32'h8, 60);
    repeat (DWELL - 1) @(negedge clk_16ms);
    bus.clear_mask = 1'b1;
    @(negedge clk_16ms);
    bus.clear_mask = 1'b0;
    check("clr_cap_mask", 32'(bus.fault_mask), 32'h8);
    bus.ch_fault = '0;

    // Randomized run control, fault flags and clears.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_16ms);
      if ($urandom_range(99) < 3) bus.start = ~bus.start;
      bus.ch_fault   = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
      bus.clear_mask = ($urandom_range(99) < 4);
    end
    bus.ch_fault = '0;
    bus.start    = 1'b1;
    pulse_clear();

    // Reset in the middle of an enable window.
    wait_for("en_before_rst", OBS_EN, 32'h1, 200);
    rst = 1'b1;
    @(negedge clk_16ms);
    check("rst_mid_en",   32'(bus.ch_enable),  32'h0);
    check("rst_mid_sel",  32'(bus.sen_sel),    32'h0);
    check("rst_mid_mask", 32'(bus.fault_mask), 32'h0);
    check("rst_mid_busy", 32'(bus.busy),       32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk_16ms);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
